// File: rtl/serial_shift_right_unit.sv
// Multi-cycle right shifter (LSR/ASR/ROR) with a Start/Done handshake, one bit per clock.
// Optional SSRU_MULTI_STEP_EN: step four bits per clock while at least four remain.
module serial_shift_right_unit #(
  parameter int WIDTH   = 20,
  parameter int SHAMT_W = 5
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [1:0]         Mode,
  input  logic [WIDTH-1:0]   DataA,
  input  logic [SHAMT_W-1:0] ShiftAmount,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ASR = 2'd1;
  localparam logic [1:0] MODE_ROR = 2'd2;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     shift_reg, shift_nxt;
  logic [SHAMT_W-1:0]   count, count_nxt;
  logic [1:0]           mode_q, mode_nxt;
  logic [SHAMT_W-1:0]   step;
  logic [WIDTH-1:0]     shifted;
  logic                 fill1;
  logic [WIDTH-1:0]     shr1;

  always_comb begin
    case (mode_q)
      MODE_ASR: fill1 = shift_reg[WIDTH-1];
      MODE_ROR: fill1 = shift_reg[0];
      default:  fill1 = 1'b0;
    endcase
    shr1 = {fill1, shift_reg[WIDTH-1:1]};
  end

`ifdef SSRU_MULTI_STEP_EN
  logic             step4;
  logic [3:0]       fill4;
  logic [WIDTH-1:0] shr4;

  always_comb begin
    step4 = |count[SHAMT_W-1:2];
    case (mode_q)
      MODE_ASR: fill4 = {4{shift_reg[WIDTH-1]}};
      MODE_ROR: fill4 = shift_reg[3:0];
      default:  fill4 = '0;
    endcase
    shr4    = {fill4, shift_reg[WIDTH-1:4]};
    step    = step4 ? SHAMT_W'(4) : SHAMT_W'(1);
    shifted = step4 ? shr4 : shr1;
  end
`else
  always_comb begin
    step    = SHAMT_W'(1);
    shifted = shr1;
  end
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      count     <= '0;
      mode_q    <= '0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      count     <= count_nxt;
      mode_q    <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    count_nxt = count;
    mode_nxt  = mode_q;
    case (state)
      S_SHIFT: begin
        shift_nxt = shifted;
        count_nxt = count - step;
        // count never reaches zero inside SHIFT; the final step lands exactly on it
        if (count == step) state_nxt = S_DONE;
      end
      default: begin
        if (Start) begin
          shift_nxt = DataA;
          count_nxt = ShiftAmount;
          mode_nxt  = Mode;
          state_nxt = (ShiftAmount == '0) ? S_DONE : S_SHIFT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  assign Busy   = (state == S_SHIFT);
  assign Done   = (state == S_DONE);
  assign Result = shift_reg;

endmodule

// File: tb/tb_serial_shift_right_unit.sv
// Directed self-checking bench for serial_shift_right_unit (either build of the step option).
module tb_serial_shift_right_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [19:0] data_a = '0;
  logic [4:0]  shamt = '0;
  logic        busy, done;
  logic [19:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  serial_shift_right_unit #(.WIDTH(20), .SHAMT_W(5)) dut (
    .Clock(clk), .Reset(rst), .Start(start), .Mode(mode), .DataA(data_a),
    .ShiftAmount(shamt), .Busy(busy), .Done(done), .Result(result)
  );

  always #5 clk = ~clk;

  function automatic int lat(input int n);
`ifdef SSRU_MULTI_STEP_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request at a falling edge, hold it over one rising edge, then scramble the inputs.
  task automatic issue(input logic [1:0] m, input logic [19:0] a, input logic [4:0] n);
    @(negedge clk);
    start = 1'b1; mode = m; data_a = a; shamt = n;
    @(posedge clk);
    #1;
    start = 1'b0; mode = ~m; data_a = ~a; shamt = n ^ 5'h1F;
  endtask

  // Called just after the accepting edge; returns at the falling edge where Done is high.
  task automatic wait_done(input logic [19:0] exp, input int exp_edges, input int exp_busy,
                           input bit poke, input string tag);
    int edges = 1;
    int busy_cnt = 0;
    @(negedge clk);
    while (done !== 1'b1 && edges < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (poke) begin
        start = busy; data_a = 20'hFFFFF; shamt = 5'd1; mode = 2'd2;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start = 1'b0;
    chk(32'(done), 32'd1, {tag, "_done"});
    chk(32'(edges), 32'(exp_edges), {tag, "_edges"});
    chk(32'(busy_cnt), 32'(exp_busy), {tag, "_busy"});
    chk(32'(result), 32'(exp), {tag, "_result"});
  endtask

  task automatic op(input logic [1:0] m, input logic [19:0] a, input logic [4:0] n,
                    input logic [19:0] exp, input string tag);
    issue(m, a, n);
    wait_done(exp, lat(int'(n)), lat(int'(n)) - 1, 1'b0, tag);
    @(negedge clk);
    chk(32'(done), 32'd0, {tag, "_pulse"});
    chk(32'(result), 32'(exp), {tag, "_hold"});
  endtask

  initial begin
    int done_seen;
    repeat (2) @(negedge clk);
    chk(32'(busy), 32'd0, "rst_busy");
    chk(32'(done), 32'd0, "rst_done");
    chk(32'(result), 32'd0, "rst_result");
    rst = 1'b0;

    op(2'd0, 20'h80001, 5'd4,  20'h08000, "lsr4");
    op(2'd1, 20'h80000, 5'd19, 20'hFFFFF, "asr19");
    op(2'd2, 20'h00001, 5'd1,  20'h80000, "ror1");
    op(2'd0, 20'h12345, 5'd0,  20'h12345, "n0");
    op(2'd0, 20'hFFFFF, 5'd31, 20'h00000, "lsr31");
    op(2'd2, 20'h00001, 5'd21, 20'h80000, "ror21");
    op(2'd1, 20'h7FFFF, 5'd25, 20'h00000, "asr25pos");
    op(2'd3, 20'hF0000, 5'd8,  20'h00F00, "rsvd8");
    op(2'd2, 20'h12345, 5'd8,  20'h45123, "ror8");
    op(2'd1, 20'hA5000, 5'd6,  20'hFE940, "asr6");

    // Start pulsed while busy must be ignored
    issue(2'd0, 20'h00F00, 5'd8);
    wait_done(20'h0000F, lat(8), lat(8) - 1, 1'b1, "ignore");

    // Back-to-back: new request accepted in the DONE cycle
    issue(2'd0, 20'h00010, 5'd4);
    wait_done(20'h00001, lat(4), lat(4) - 1, 1'b0, "b2b_a");
    start = 1'b1; mode = 2'd2; data_a = 20'h00003; shamt = 5'd2;
    @(posedge clk);
    #1 start = 1'b0; data_a = '0; shamt = '0; mode = '0;
    wait_done(20'hC0000, lat(2), lat(2) - 1, 1'b0, "b2b_b");

    // Asynchronous reset mid-shift
    issue(2'd0, 20'hFFFFF, 5'd10);
    repeat (3) @(negedge clk);
    chk(32'(busy), 32'd1, "mid_busy");
    rst = 1'b1;
    #1;
    chk(32'(busy), 32'd0, "arst_busy");
    chk(32'(done), 32'd0, "arst_done");
    chk(32'(result), 32'd0, "arst_result");
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    chk(32'(done_seen), 32'd0, "arst_no_done");
    op(2'd1, 20'h80000, 5'd4, 20'hF8000, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
